// File: rtl/seq_alu.sv
// seq_alu: registered, valid/ready handshaked ALU for the decode->writeback slot.
// Latency: logic/arith/shift ops and div special cases 1 cycle; mul/div WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; result and flags hold in DONE until out_ready.
// Ports: clk, rst_n (async, active low); in_valid/in_ready + AluOp/A/B on the
//    input side; out_valid/out_ready + ALUresult/Zero/illegal on the output side.
// Build option: define SEQ_ALU_MULDIV_EN to include the iterative multiply/divide
//    datapath. Without it, mul/div opcodes return 0 with illegal set in 1 cycle.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       AluOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUresult,
   output logic             Zero,
   output logic             illegal
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_SLTU  = 4'b1111;
   localparam logic [3:0] OP_SLL   = 4'b1101;
   localparam logic [3:0] OP_SRL   = 4'b1110;
   localparam logic [3:0] OP_SRA   = 4'b1000;
   localparam logic [3:0] OP_MUL   = 4'b0011;
   localparam logic [3:0] OP_MULHU = 4'b0100;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b0101;
   localparam logic [3:0] OP_REM   = 4'b1011;
   localparam logic [3:0] OP_REMU  = 4'b1001;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DONE = 2'd3;
`ifdef SEQ_ALU_MULDIV_EN
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] sc_res;
   logic             sc_ill;

`ifdef SEQ_ALU_MULDIV_EN
   // hi/lo hold {product} for multiply and {remainder, quotient} for divide;
   // opnd holds the multiplicand or the divisor magnitude.
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d;
   logic             is_md, spec_hit, sgn, is_mul;
   logic [WIDTH-1:0] spec_res, a_mag, b_mag, fix_res;
   logic [WIDTH:0]   mul_sum, div_sh, div_diff;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign ALUresult = result_q;
   assign Zero      = zero_q;
   assign illegal   = illegal_q;

   // Single-cycle result for the opcode currently on the input.
   always_comb begin
      sc_res = '0;
      sc_ill = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      is_md  = 1'b0;
`endif
      case (AluOp)
         OP_AND:  sc_res = A & B;
         OP_OR:   sc_res = A | B;
         OP_ADD:  sc_res = A + B;
         OP_SUB:  sc_res = A - B;
         OP_NOR:  sc_res = ~(A | B);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLL:  sc_res = A << B[SHW-1:0];
         OP_SRL:  sc_res = A >> B[SHW-1:0];
         OP_SRA:  sc_res = $signed(A) >>> B[SHW-1:0];
         OP_MUL, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
`ifdef SEQ_ALU_MULDIV_EN
            is_md  = 1'b1;
`else
            sc_ill = 1'b1;
`endif
         end
         default: sc_ill = 1'b1;
      endcase
   end

`ifdef SEQ_ALU_MULDIV_EN
   // Division by zero and signed overflow bypass the iterative datapath.
   always_comb begin
      spec_hit = 1'b0;
      spec_res = '0;
      case (AluOp)
         OP_DIV: begin
            if (B == '0) begin
               spec_hit = 1'b1;
               spec_res = '1;
            end else if ((A == MIN_VAL) && (B == '1)) begin
               spec_hit = 1'b1;
               spec_res = MIN_VAL;
            end
         end
         OP_DIVU: begin
            if (B == '0) begin
               spec_hit = 1'b1;
               spec_res = '1;
            end
         end
         OP_REM: begin
            if (B == '0) begin
               spec_hit = 1'b1;
               spec_res = A;
            end else if ((A == MIN_VAL) && (B == '1)) begin
               spec_hit = 1'b1;
               spec_res = '0;
            end
         end
         OP_REMU: begin
            if (B == '0) begin
               spec_hit = 1'b1;
               spec_res = A;
            end
         end
         default: ;
      endcase
   end

   assign sgn    = (AluOp == OP_DIV) || (AluOp == OP_REM);
   assign is_mul = (AluOp == OP_MUL) || (AluOp == OP_MULHU);
   assign a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
   assign b_mag  = (sgn && B[WIDTH-1]) ? -B : B;

   // Shift-add step: add multiplicand when the multiplier LSB is set, then
   // shift the whole {carry, hi, lo} right by one.
   assign mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
   // Restoring step: shift next dividend bit into the partial remainder and
   // subtract if it does not borrow. The remainder always stays below the
   // divisor, so bit WIDTH of the difference is exactly the borrow.
   assign div_sh   = {hi_q, lo_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};

   always_comb begin
      fix_res = hi_q;
      case (op_q)
         OP_MUL:   fix_res = lo_q;
         OP_MULHU: fix_res = hi_q;
         OP_DIV:   fix_res = qneg_q ? -lo_q : lo_q;
         OP_DIVU:  fix_res = lo_q;
         OP_REM:   fix_res = rneg_q ? -hi_q : hi_q;
         default:  fix_res = hi_q;
      endcase
   end
`endif

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef SEQ_ALU_MULDIV_EN
      hi_d   = hi_q;
      lo_d   = lo_q;
      opnd_d = opnd_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
               if (is_md && !spec_hit) begin
                  hi_d    = '0;
                  lo_d    = is_mul ? B : a_mag;
                  opnd_d  = is_mul ? A : b_mag;
                  cnt_d   = '0;
                  op_d    = AluOp;
                  qneg_d  = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                  rneg_d  = sgn && A[WIDTH-1];
                  state_d = CALC;
               end else begin
                  result_d  = is_md ? spec_res : sc_res;
                  zero_d    = is_md ? (spec_res == '0) : (sc_res == '0);
                  illegal_d = is_md ? 1'b0 : sc_ill;
                  state_d   = DONE;
               end
`else
               result_d  = sc_res;
               zero_d    = (sc_res == '0);
               illegal_d = sc_ill;
               state_d   = DONE;
`endif
            end
         end
`ifdef SEQ_ALU_MULDIV_EN
         CALC: begin
            if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
               hi_d = mul_sum[WIDTH:1];
               lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
               hi_d = div_diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_sh[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d  = fix_res;
            zero_d    = (fix_res == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
         hi_q   <= '0;
         lo_q   <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
`ifdef SEQ_ALU_MULDIV_EN
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
`endif
      end
   end

endmodule
